// File: rtl/serial_fa_adder.sv
// Bit-serial ripple adder: feeds one bit pair per clock through a single full-adder cell.
// Optional build macro SERIAL_FA_SUB_EN adds a `sub` port for a - b (two's complement).

module fa (
    input  logic [2:0] x,
    output logic       s,
    output logic       c
);
    assign s = ^x;
    assign c = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
endmodule

module serial_fa_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_FA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d, acc_sh_q, acc_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d, cout_q, cout_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               fa_s, fa_c;
    logic [WIDTH-1:0]   b_in;
    logic               c_in;

    // Subtraction is a + ~b + 1, so only the B operand and carry seed change.
`ifdef SERIAL_FA_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    fa u_fa (
        .x ({carry_q, b_sh_q[0], a_sh_q[0]}),
        .s (fa_s),
        .c (fa_c)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_sh_d = acc_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_in;
                    carry_d = c_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                acc_sh_d = {fa_s, acc_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + 1'b1;
                // Last bit: publish the whole result at once so sum never shows partial data.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {fa_s, acc_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_sh_q <= acc_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_fa_adder.sv
// Directed and table-driven bench for serial_fa_adder (WIDTH=8 and WIDTH=4 instances).
// Define SERIAL_FA_SUB_EN on both files to exercise the subtract mode.

module tb_serial_fa_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, sub8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8;
    logic       start4, cin4;
    logic [3:0] a4, b4, sum4;
    logic       busy4, done4, cout4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_fa_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_FA_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_fa_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_FA_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where done rose.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic ts, output int lat, output logic busy_ok);
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        busy_ok = busy8;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (done8) begin
                lat = n - 1;
                break;
            end
            if (!busy8) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL op8_timeout: no done within 40 cycles");
        end
    endtask

    int         lat, dcount, gap, first_lat, period;
    logic       bok;
    logic [7:0] hold8;
    logic [4:0] exp5;
    logic [3:0] held4;

    initial begin
        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        @(posedge clk); #1;
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_sum", sum8, 0);
        check("reset_cout", cout8, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, lat, bok);
            check($sformatf("vec%0d_sum", i), sum8, vecs[i].exp_sum);
            check($sformatf("vec%0d_cout", i), cout8, vecs[i].exp_cout);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_busy_run", i), bok, 1);
            check($sformatf("vec%0d_busy_at_done", i), busy8, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), done8, 0);
            @(posedge clk); #1;
        end

        // start pulsed mid-operation must be ignored
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 0; start8 = 1;
        @(posedge clk); #1; start8 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a8 = 8'h01; start8 = 1;
        @(posedge clk); #1; start8 = 0;
        for (int e = 4; e <= 7; e++) begin
            @(posedge clk); #1;
        end
        check("repulse_busy_e7", busy8, 1);
        check("repulse_done_e7", done8, 0);
        @(posedge clk); #1;
        check("repulse_done_e8", done8, 1);
        check("repulse_sum", sum8, 8'h4B);
        check("repulse_cout", cout8, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("repulse_no_requeue", busy8, 0);

        // reset mid-run aborts
        a8 = 8'hAA; b8 = 8'h55; cin8 = 0; start8 = 1;
        @(posedge clk); #1; start8 = 0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
        end
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcount = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (done8) dcount++;
        end
        check("abort_no_done", dcount, 0);
        op8(8'h10, 8'h20, 1'b0, 1'b0, lat, bok);
        check("after_abort_sum", sum8, 8'h30);
        check("after_abort_cout", cout8, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // start held high re-triggers every WIDTH+2 cycles
        a8 = 8'h01; b8 = 8'h02; cin8 = 0; start8 = 1;
        first_lat = -1; period = -1;
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                if (first_lat < 0) first_lat = n;
                else begin
                    period = n - first_lat;
                    break;
                end
            end
        end
        start8 = 0;
        check("hold_first_latency", first_lat, 8);
        check("hold_period", period, 10);
        check("hold_sum", sum8, 8'h03);
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
        end
        check("hold_back_idle", busy8, 0);

`ifdef SERIAL_FA_SUB_EN
        op8(8'h05, 8'h07, 1'b0, 1'b1, lat, bok);
        check("sub_5m7_sum", sum8, 8'hFE);
        check("sub_5m7_cout", cout8, 0);
        @(posedge clk); #1; @(posedge clk); #1;
        op8(8'h07, 8'h05, 1'b1, 1'b1, lat, bok);
        check("sub_7m5_sum", sum8, 8'h02);
        check("sub_7m5_cout", cout8, 1);
        @(posedge clk); #1; @(posedge clk); #1;
        op8(8'h07, 8'h05, 1'b1, 1'b0, lat, bok);
        check("sub0_add_sum", sum8, 8'h0D);
        check("sub0_add_cout", cout8, 0);
        @(posedge clk); #1; @(posedge clk); #1;
`endif

        // exhaustive WIDTH=4 sweep with random idle gaps
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1;
                    @(posedge clk); #1; start4 = 0;
                    lat = -1;
                    for (int n = 1; n <= 20; n++) begin
                        @(posedge clk); #1;
                        if (done4) begin
                            lat = n;
                            break;
                        end
                    end
                    exp5 = 5'(ia + ib + ic);
                    check($sformatf("w4_%0d_%0d_%0d", ia, ib, ic), {lat[7:0], 3'b0, cout4, sum4},
                          {8'd4, 3'b0, exp5});
                    held4 = sum4;
                    @(posedge clk); #1;
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) begin
                        @(posedge clk); #1;
                    end
                    checks++;
                    if (sum4 !== held4 || busy4 !== 1'b0) begin
                        errors++;
                        $display("FAIL w4_hold_%0d_%0d_%0d: got 0x%0h busy %0b expected 0x%0h busy 0",
                                 ia, ib, ic, sum4, busy4, held4);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
